// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle IF/ID/EX/MEM/WB control sequencer with retire and cycle counters
module multicycle_sequencer #(
  parameter int PC_WIDTH  = 3,
  parameter int LAST_PC   = 7,
  parameter int CNT_WIDTH = 16,
  parameter int EX_WAIT   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  program_counter,
  input  logic                 mem_op,
  input  logic                 ex_done,
  input  logic                 mem_ready,
  input  logic                 halt,
  input  logic                 restart,
  output logic [2:0]           state,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [CNT_WIDTH-1:0] cycles
);

  typedef enum logic [2:0] {
    ST_IF     = 3'd0,
    ST_ID     = 3'd1,
    ST_EX     = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_OUTPUT = 3'd5
  } state_t;

  localparam logic [PC_WIDTH-1:0]  LAST_PC_V = PC_WIDTH'(LAST_PC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t                state_q;
  state_t                state_d;
  logic                  mem_q;
  logic                  mem_d;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic [CNT_WIDTH-1:0]  cycles_q;
  logic                  ex_go;

  // ex_done only gates EX when the wait option is built in
  assign ex_go = (EX_WAIT == 0) || ex_done;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        state_d = ST_EX;
        mem_d   = mem_op;
      end
      ST_EX: begin
        if (ex_go) state_d = mem_q ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) state_d = ST_WB;
      end
      ST_WB: begin
        if ((program_counter < LAST_PC_V) && !halt) state_d = ST_IF;
        else                                        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (restart) state_d = ST_IF;
      end
      default: state_d = ST_OUTPUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IF;
      mem_q     <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      if ((state_q == ST_OUTPUT) && restart) begin
        retired_q <= '0;
        cycles_q  <= '0;
      end else begin
        // both counters saturate instead of wrapping
        if ((state_q == ST_WB) && (retired_q != CNT_MAX)) retired_q <= retired_q + 1'b1;
        if ((state_q != ST_OUTPUT) && (cycles_q != CNT_MAX)) cycles_q <= cycles_q + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign done    = (state_q == ST_OUTPUT);
  assign retired = retired_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [2:0]  program_counter;
  logic        mem_op;
  logic        ex_done;
  logic        mem_ready;
  logic        halt;
  logic        restart;

  logic [2:0]  s0, s1, s2;
  logic        d0, d1, d2;
  logic [15:0] r0, c0, r1, c1;
  logic [2:0]  r2, c2;

  int checks = 0;
  int errors = 0;

  multicycle_sequencer #(.PC_WIDTH(3), .LAST_PC(7), .CNT_WIDTH(16), .EX_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .program_counter(program_counter), .mem_op(mem_op),
    .ex_done(ex_done), .mem_ready(mem_ready), .halt(halt), .restart(restart),
    .state(s0), .done(d0), .retired(r0), .cycles(c0));

  multicycle_sequencer #(.PC_WIDTH(3), .LAST_PC(7), .CNT_WIDTH(16), .EX_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .program_counter(program_counter), .mem_op(mem_op),
    .ex_done(ex_done), .mem_ready(mem_ready), .halt(halt), .restart(restart),
    .state(s1), .done(d1), .retired(r1), .cycles(c1));

  multicycle_sequencer #(.PC_WIDTH(3), .LAST_PC(7), .CNT_WIDTH(3), .EX_WAIT(0)) dut2 (
    .clk(clk), .reset(reset), .program_counter(program_counter), .mem_op(mem_op),
    .ex_done(ex_done), .mem_ready(mem_ready), .halt(halt), .restart(restart),
    .state(s2), .done(d2), .retired(r2), .cycles(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; program_counter = 3'd0; mem_op = 1'b0; ex_done = 1'b1;
    mem_ready = 1'b1; halt = 1'b0; restart = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (s0 !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", s0); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", d0); end
    checks++; if (r0 !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", r0); end
    checks++; if (c0 !== 16'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", c0); end
    checks++; if (s1 !== 3'd0) begin errors++; $display("FAIL reset_state_exwait: got %0d expected 0", s1); end
  endtask

  task automatic test_sequential;
    logic [2:0] seq [4];
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd4;
    mem_op = 1'b0; mem_ready = 1'b1; halt = 1'b0; ex_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      program_counter = 3'(i);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (s0 !== seq[c]) begin errors++; $display("FAIL seq_state i=%0d c=%0d: got %0d expected %0d", i, c, s0, seq[c]); end
        tick();
      end
    end
    checks++; if (s0 !== 3'd5) begin errors++; $display("FAIL seq_end_state: got %0d expected 5", s0); end
    checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL seq_done: got %0d expected 1", d0); end
    checks++; if (r0 !== 16'd8) begin errors++; $display("FAIL seq_retired: got %0d expected 8", r0); end
    checks++; if (c0 !== 16'd32) begin errors++; $display("FAIL seq_cycles: got %0d expected 32", c0); end
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL seq_done_exwait: got %0d expected 1", d1); end
    checks++; if (r2 !== 3'd7) begin errors++; $display("FAIL seq_retired_sat: got %0d expected 7", r2); end
    checks++; if (c2 !== 3'd7) begin errors++; $display("FAIL seq_cycles_sat: got %0d expected 7", c2); end
  endtask

  task automatic test_restart;
    tick();
    checks++; if (s0 !== 3'd5) begin errors++; $display("FAIL output_hold: got %0d expected 5", s0); end
    checks++; if (c0 !== 16'd32) begin errors++; $display("FAIL output_cycles_frozen: got %0d expected 32", c0); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (s0 !== 3'd0) begin errors++; $display("FAIL restart_state: got %0d expected 0", s0); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL restart_done: got %0d expected 0", d0); end
    checks++; if (r0 !== 16'd0) begin errors++; $display("FAIL restart_retired: got %0d expected 0", r0); end
    checks++; if (c0 !== 16'd0) begin errors++; $display("FAIL restart_cycles: got %0d expected 0", c0); end
    checks++; if (r2 !== 3'd0) begin errors++; $display("FAIL restart_retired_sat: got %0d expected 0", r2); end
  endtask

  task automatic test_halt;
    logic [2:0] seq6 [6];
    logic [2:0] seq4 [4];
    seq6[0] = 3'd0; seq6[1] = 3'd1; seq6[2] = 3'd2; seq6[3] = 3'd3; seq6[4] = 3'd3; seq6[5] = 3'd4;
    seq4[0] = 3'd0; seq4[1] = 3'd1; seq4[2] = 3'd2; seq4[3] = 3'd4;
    // halt and restart asserted in every non-WB state of a MEM instruction must do nothing
    program_counter = 3'd0; mem_op = 1'b1;
    for (int c = 0; c < 6; c++) begin
      halt = (c != 5);
      restart = (c != 5);
      mem_ready = (c != 3);
      checks++;
      if (s0 !== seq6[c]) begin errors++; $display("FAIL halt_ignored c=%0d: got %0d expected %0d", c, s0, seq6[c]); end
      tick();
    end
    halt = 1'b0; restart = 1'b0; mem_ready = 1'b1; mem_op = 1'b0;
    program_counter = 3'd1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (s0 !== seq4[c]) begin errors++; $display("FAIL halt_pc1 c=%0d: got %0d expected %0d", c, s0, seq4[c]); end
      tick();
    end
    program_counter = 3'd2;
    for (int c = 0; c < 4; c++) begin
      halt = (c == 3);
      checks++;
      if (s0 !== seq4[c]) begin errors++; $display("FAIL halt_pc2 c=%0d: got %0d expected %0d", c, s0, seq4[c]); end
      tick();
    end
    halt = 1'b0;
    checks++; if (s0 !== 3'd5) begin errors++; $display("FAIL halt_state: got %0d expected 5", s0); end
    checks++; if (r0 !== 16'd3) begin errors++; $display("FAIL halt_retired: got %0d expected 3", r0); end
    checks++; if (c0 !== 16'd14) begin errors++; $display("FAIL halt_cycles: got %0d expected 14", c0); end
    checks++; if (s1 !== 3'd5) begin errors++; $display("FAIL halt_state_exwait: got %0d expected 5", s1); end
  endtask

  task automatic test_reset_priority;
    reset = 1'b1; restart = 1'b1;
    tick();
    reset = 1'b0; restart = 1'b0;
    checks++; if (s0 !== 3'd0) begin errors++; $display("FAIL rst_restart_state: got %0d expected 0", s0); end
    checks++; if (r0 !== 16'd0) begin errors++; $display("FAIL rst_restart_retired: got %0d expected 0", r0); end
    checks++; if (c0 !== 16'd0) begin errors++; $display("FAIL rst_restart_cycles: got %0d expected 0", c0); end
    program_counter = 3'd0; mem_op = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (s0 !== 3'd3) begin errors++; $display("FAIL mem_wait_state: got %0d expected 3", s0); end
    checks++; if (c0 !== 16'd4) begin errors++; $display("FAIL mem_wait_cycles: got %0d expected 4", c0); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    checks++; if (s0 !== 3'd0) begin errors++; $display("FAIL rst_mid_mem_state: got %0d expected 0", s0); end
    checks++; if (c0 !== 16'd0) begin errors++; $display("FAIL rst_mid_mem_cycles: got %0d expected 0", c0); end
  endtask

  task automatic test_mem_wait;
    logic [2:0] seq7 [7];
    seq7[0] = 3'd0; seq7[1] = 3'd1; seq7[2] = 3'd2; seq7[3] = 3'd3;
    seq7[4] = 3'd3; seq7[5] = 3'd3; seq7[6] = 3'd4;
    mem_op = 1'b1; halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      program_counter = 3'(i);
      for (int c = 0; c < 7; c++) begin
        mem_ready = !(c == 3 || c == 4);
        checks++;
        if (s0 !== seq7[c]) begin errors++; $display("FAIL mem_seq i=%0d c=%0d: got %0d expected %0d", i, c, s0, seq7[c]); end
        tick();
      end
      checks++;
      if (r0 !== 16'(i + 1)) begin errors++; $display("FAIL mem_retired i=%0d: got %0d expected %0d", i, r0, i + 1); end
    end
    mem_ready = 1'b1;
    checks++; if (c0 !== 16'd14) begin errors++; $display("FAIL mem_cycles: got %0d expected 14", c0); end
    checks++; if (s0 !== 3'd0) begin errors++; $display("FAIL mem_next_if: got %0d expected 0", s0); end
  endtask

  task automatic test_ex_wait;
    logic [2:0] seq7 [7];
    seq7[0] = 3'd0; seq7[1] = 3'd1; seq7[2] = 3'd2; seq7[3] = 3'd2;
    seq7[4] = 3'd2; seq7[5] = 3'd2; seq7[6] = 3'd4;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_op = 1'b0; mem_ready = 1'b1; program_counter = 3'd0;
    for (int c = 0; c < 7; c++) begin
      ex_done = !(c >= 2 && c <= 4);
      checks++;
      if (s1 !== seq7[c]) begin errors++; $display("FAIL exwait_seq c=%0d: got %0d expected %0d", c, s1, seq7[c]); end
      if (c == 3) begin
        checks++;
        if (s0 !== 3'd4) begin errors++; $display("FAIL exwait_ignored: got %0d expected 4", s0); end
      end
      tick();
    end
    ex_done = 1'b1;
    checks++; if (s1 !== 3'd0) begin errors++; $display("FAIL exwait_end_state: got %0d expected 0", s1); end
    checks++; if (r1 !== 16'd1) begin errors++; $display("FAIL exwait_retired: got %0d expected 1", r1); end
    checks++; if (c1 !== 16'd7) begin errors++; $display("FAIL exwait_cycles: got %0d expected 7", c1); end
    checks++; if (s0 !== 3'd4) begin errors++; $display("FAIL noexwait_state: got %0d expected 4", s0); end
    checks++; if (r0 !== 16'd1) begin errors++; $display("FAIL noexwait_retired: got %0d expected 1", r0); end
  endtask

  task automatic test_saturation;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_op = 1'b0; mem_ready = 1'b1; ex_done = 1'b1; program_counter = 3'd0;
    for (int c = 0; c < 7; c++) tick();
    checks++; if (c2 !== 3'd7) begin errors++; $display("FAIL sat_cycles_7: got %0d expected 7", c2); end
    checks++; if (r2 !== 3'd1) begin errors++; $display("FAIL sat_retired_1: got %0d expected 1", r2); end
    tick();
    checks++; if (c2 !== 3'd7) begin errors++; $display("FAIL sat_cycles_nowrap: got %0d expected 7", c2); end
    checks++; if (r2 !== 3'd2) begin errors++; $display("FAIL sat_retired_2: got %0d expected 2", r2); end
    for (int c = 0; c < 32; c++) tick();
    checks++; if (r2 !== 3'd7) begin errors++; $display("FAIL sat_retired_7: got %0d expected 7", r2); end
    checks++; if (c2 !== 3'd7) begin errors++; $display("FAIL sat_cycles_end: got %0d expected 7", c2); end
    checks++; if (s2 !== 3'd0 || d2 !== 1'b0) begin errors++; $display("FAIL sat_state: got %0d/%0d expected 0/0", s2, d2); end
    checks++; if (r0 !== 16'd10) begin errors++; $display("FAIL wide_retired: got %0d expected 10", r0); end
    checks++; if (c0 !== 16'd40) begin errors++; $display("FAIL wide_cycles: got %0d expected 40", c0); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_restart();
    test_halt();
    test_reset_priority();
    test_mem_wait();
    test_ex_wait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- PC_WIDTH, 3, program counter width.
- LAST_PC, 7, highest PC that still fetches another instruction; PC < LAST_PC continues.
- CNT_WIDTH, 16, width of the retire and cycle counters.
- EX_WAIT, 0; when 1, EX holds until ex_done.
REQ-002 The block SHALL have these ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high.
- program_counter, input, PC_WIDTH, current PC from datapath.
- mem_op, input, 1, decoded instruction needs MEM; valid in ID.
- ex_done, input, 1, EX complete; used only when EX_WAIT=1.
- mem_ready, input, 1, memory access complete.
- halt, input, 1, early-termination request.
- restart, input, 1, leave OUTPUT and rerun the program.
- state, output, 3, current state.
- done, output, 1, high iff state==OUTPUT.
- retired, output, CNT_WIDTH, instructions retired.
- cycles, output, CNT_WIDTH, clock cycles spent outside OUTPUT.

Function
REQ-003 State encoding SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, OUTPUT=5; codes 6 and 7 are illegal.
REQ-004 The state register SHALL make one transition per rising clk edge, per REQ-005 to REQ-011.
REQ-005 IF SHALL go to ID unconditionally.
REQ-006 ID SHALL go to EX and capture mem_op into an internal flag mem_q.
REQ-007 EX SHALL go to MEM when mem_q=1 and to WB when mem_q=0.
- With EX_WAIT=1, EX SHALL hold until a cycle with ex_done=1.
- With EX_WAIT=0, ex_done SHALL be ignored.
REQ-008 MEM SHALL hold while mem_ready=0 and go to WB in the first cycle mem_ready=1, with no timeout.
REQ-009 WB SHALL go to IF when program_counter < LAST_PC (unsigned) and halt=0; otherwise WB SHALL go to OUTPUT.
REQ-010 halt and program_counter SHALL be sampled only in WB; halt in any other state SHALL have no effect.
REQ-011 OUTPUT SHALL hold until restart=1, then go to IF.
- The restart transition SHALL clear retired and cycles to 0 on the same edge.
- restart outside OUTPUT SHALL be ignored.
REQ-012 An illegal state code SHALL go to OUTPUT on the next edge.
REQ-013 retired SHALL increment by 1 on every edge leaving WB, and SHALL saturate at 2^CNT_WIDTH-1.
REQ-014 cycles SHALL increment by 1 on every edge where state!=OUTPUT before the edge, and SHALL saturate at 2^CNT_WIDTH-1.
REQ-015 done SHALL be a combinational decode of state, with no extra latency.
REQ-016 Minimum instruction latency SHALL be 4 cycles without MEM (IF, ID, EX, WB) and 5 cycles with MEM and mem_ready=1.
- Each wait cycle SHALL add one cycle.

Reset
REQ-017 reset=1 at a rising edge SHALL set state=IF, mem_q=0, retired=0 and cycles=0, so done=0 after the edge.
REQ-018 reset SHALL take priority over every other input, including mid-MEM-wait and restart in OUTPUT.
REQ-019 The first state after reset SHALL be IF, and no initial-block reliance SHALL be permitted.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- (a) EX_WAIT=0, mem_op=0, PC stepping 0..7 each WB, mem_ready=1: 8 instructions of 4 cycles each; OUTPUT after the 32nd edge; retired=8, cycles=32, done=1.
- (b) mem_op=1 on every instruction, mem_ready low for 2 cycles per access: each instruction takes 7 cycles; state sequence 0,1,2,3,3,3,4.
- (c) halt=1 in WB with PC=2: next state=OUTPUT, retired=3; halt pulses in IF, ID, EX and MEM cause no change.
- (d) EX_WAIT=1, ex_done low 3 cycles: EX held 4 cycles; with EX_WAIT=0 the same stimulus does not hold EX.
- (e) In OUTPUT, restart=1 for one cycle: state=IF, retired=0, cycles=0; simultaneous reset=1 and restart=1 gives the same state with counters 0 via reset; reset asserted mid-MEM-wait gives IF next edge.
- (f) CNT_WIDTH=3, long run: retired and cycles stick at 7, with no wrap to 0.
